// File: rtl/lsu_lq_ring_pkg.sv
// Shared LSU types: the load/store function encoding, the load-queue slot
// status struct, and the helper that converts an LSU function to its access
// size in bytes.
// Ports: none (package).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 6
`endif
`ifndef LQ_DEPTH
`define LQ_DEPTH 8
`endif

package lsu_lq_ring_pkg;

  localparam int unsigned LSU_SIZE_W = 3;

  typedef enum logic [2:0] {
    LSU_LB  = 3'd0,
    LSU_LH  = 3'd1,
    LSU_LW  = 3'd2,
    LSU_LBU = 3'd3,
    LSU_LHU = 3'd4,
    LSU_SB  = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SW  = 3'd7
  } lsu_func_t;

  // Per-slot status bits; tag/addr/size live in separate, non-reset storage.
  typedef struct packed {
    logic valid;
    logic addr_valid;
    logic mis_speculated;
  } lq_slot_t;

  // Access width in bytes for a load or store function.
  function automatic logic [LSU_SIZE_W-1:0] lsu_func_size(input lsu_func_t func);
    logic [LSU_SIZE_W-1:0] size;
    case (func)
      LSU_LB, LSU_LBU, LSU_SB: size = LSU_SIZE_W'(1);
      LSU_LH, LSU_LHU, LSU_SH: size = LSU_SIZE_W'(2);
      default:                 size = LSU_SIZE_W'(4);
    endcase
    return size;
  endfunction

endpackage

// File: rtl/lsu_lq_ring_addr_overlap.sv
// lsu_addr_overlap: flags whether two byte ranges [addr, addr+size) intersect.
// Ends are computed one bit wider than the address so a range touching the top
// of the address space does not wrap to zero.
// Ports: i_a_addr/i_a_size, i_b_addr/i_b_size in; o_overlap_c out (combinational).
module lsu_addr_overlap
  import lsu_lq_ring_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [LSU_SIZE_W-1:0] i_a_size,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic [LSU_SIZE_W-1:0] i_b_size,
  output logic                  o_overlap_c
);

  localparam int unsigned EXT_W = ADDR_WIDTH + 1;

  logic [EXT_W-1:0] a_lo;
  logic [EXT_W-1:0] a_hi;
  logic [EXT_W-1:0] b_lo;
  logic [EXT_W-1:0] b_hi;

  assign a_lo = EXT_W'(i_a_addr);
  assign b_lo = EXT_W'(i_b_addr);
  assign a_hi = a_lo + EXT_W'(i_a_size);
  assign b_hi = b_lo + EXT_W'(i_b_size);

  assign o_overlap_c = (a_lo < b_hi) && (b_lo < a_hi);

endmodule

// File: rtl/lsu_lq_ring.sv
// lsu_lq_ring: circular load queue. Loads are allocated in program order at
// the tail, receive their address when executed, are marked mis-speculated
// when an older overlapping store commits, and retire in order from the head.
// Ports:
//   clk, n_rst                      clock, async active-low reset
//   i_flush                         discard all entries
//   o_full, o_empty                 occupancy status
//   i_alloc_en/i_alloc_tag          allocate at tail; o_alloc_slot = tail index
//   i_update_*                      executed-load address/size into a slot
//   i_sq_retire_*                   committing store address/size/tag
//   i_rob_head_tag                  age origin for tag comparisons
//   i_rob_retire_en/_tag            in-order retire of the head load
//   o_rob_retire_mis_speculated     head load must be replayed
module lsu_lq_ring
  import lsu_lq_ring_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
  parameter int unsigned TAG_WIDTH  = `TAG_WIDTH,
  parameter int unsigned LQ_DEPTH   = `LQ_DEPTH
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        i_flush,
  output logic                        o_full,
  output logic                        o_empty,
  input  logic                        i_alloc_en,
  input  logic [TAG_WIDTH-1:0]        i_alloc_tag,
  output logic [$clog2(LQ_DEPTH)-1:0] o_alloc_slot,
  input  logic                        i_update_en,
  input  logic [$clog2(LQ_DEPTH)-1:0] i_update_slot,
  input  logic [ADDR_WIDTH-1:0]       i_update_addr,
  input  lsu_func_t                   i_update_lsu_func,
  input  logic                        i_sq_retire_en,
  input  logic [ADDR_WIDTH-1:0]       i_sq_retire_addr,
  input  lsu_func_t                   i_sq_retire_lsu_func,
  input  logic [TAG_WIDTH-1:0]        i_sq_retire_tag,
  input  logic [TAG_WIDTH-1:0]        i_rob_head_tag,
  input  logic                        i_rob_retire_en,
  input  logic [TAG_WIDTH-1:0]        i_rob_retire_tag,
  output logic                        o_rob_retire_mis_speculated
);

  localparam int unsigned PTR_W = $clog2(LQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  lq_slot_t [LQ_DEPTH-1:0] slot_q, slot_d;
  logic [TAG_WIDTH-1:0]    tag_q  [LQ_DEPTH];
  logic [TAG_WIDTH-1:0]    tag_d  [LQ_DEPTH];
  logic [ADDR_WIDTH-1:0]   addr_q [LQ_DEPTH];
  logic [ADDR_WIDTH-1:0]   addr_d [LQ_DEPTH];
  logic [LSU_SIZE_W-1:0]   size_q [LQ_DEPTH];
  logic [LSU_SIZE_W-1:0]   size_d [LQ_DEPTH];
  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic                    full;
  logic                    empty;
  logic                    alloc_ok;
  logic                    retire_ok;
  logic [LSU_SIZE_W-1:0]   upd_size;
  logic [LSU_SIZE_W-1:0]   sq_size;
  logic [TAG_WIDTH-1:0]    sq_age;
  logic [LQ_DEPTH-1:0]     upd_hit;
  logic [LQ_DEPTH-1:0]     younger;
  logic [LQ_DEPTH-1:0]     overlap;

  assign full      = (count_q == CNT_W'(LQ_DEPTH));
  assign empty     = (count_q == '0);
  assign alloc_ok  = i_alloc_en && !full;
  assign retire_ok = i_rob_retire_en && !empty;
  assign upd_size  = lsu_func_size(i_update_lsu_func);
  assign sq_size   = lsu_func_size(i_sq_retire_lsu_func);
  assign sq_age    = i_sq_retire_tag - i_rob_head_tag;

  // Per-slot age and overlap against the committing store. A same-cycle
  // address update is compared instead of the stale stored address.
  for (genvar g = 0; g < LQ_DEPTH; g++) begin : g_slot
    logic [TAG_WIDTH-1:0]  ld_age;
    logic [ADDR_WIDTH-1:0] chk_addr;
    logic [LSU_SIZE_W-1:0] chk_size;

    assign upd_hit[g] = i_update_en && (i_update_slot == PTR_W'(g)) && slot_q[g].valid;
    assign ld_age     = tag_q[g] - i_rob_head_tag;
    assign younger[g] = ld_age > sq_age;
    assign chk_addr   = upd_hit[g] ? i_update_addr : addr_q[g];
    assign chk_size   = upd_hit[g] ? upd_size : size_q[g];

    lsu_addr_overlap #(
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_overlap (
      .i_a_addr    (chk_addr),
      .i_a_size    (chk_size),
      .i_b_addr    (i_sq_retire_addr),
      .i_b_size    (sq_size),
      .o_overlap_c (overlap[g])
    );
  end

  // Next-state: flush dominates; otherwise update, store check, retire, alloc.
  always_comb begin
    slot_d  = slot_q;
    tag_d   = tag_q;
    addr_d  = addr_q;
    size_d  = size_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (i_flush) begin
      slot_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
        if (upd_hit[i]) begin
          addr_d[i]            = i_update_addr;
          size_d[i]            = upd_size;
          slot_d[i].addr_valid = 1'b1;
        end
        if (i_sq_retire_en && slot_q[i].valid && (slot_q[i].addr_valid || upd_hit[i]) &&
            younger[i] && overlap[i]) begin
          slot_d[i].mis_speculated = 1'b1;
        end
      end

      if (retire_ok) begin
        slot_d[head_q].valid = 1'b0;
        head_d               = head_q + PTR_W'(1);
      end

      // alloc_ok implies the tail slot is free, so it never collides with the
      // retiring head or an update to a live slot.
      if (alloc_ok) begin
        tag_d[tail_q]                 = i_alloc_tag;
        slot_d[tail_q].valid          = 1'b1;
        slot_d[tail_q].addr_valid     = 1'b0;
        slot_d[tail_q].mis_speculated = 1'b0;
        tail_d                        = tail_q + PTR_W'(1);
      end

      if (alloc_ok && !retire_ok) begin
        count_d = count_q + CNT_W'(1);
      end else if (!alloc_ok && retire_ok) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Control state with async reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      slot_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      slot_q  <= slot_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage, deliberately not reset; qualified by the valid bits.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    addr_q <= addr_d;
    size_q <= size_d;
  end

  assign o_full                      = full;
  assign o_empty                     = empty;
  assign o_alloc_slot                = tail_q;
  assign o_rob_retire_mis_speculated = slot_q[head_q].valid && slot_q[head_q].mis_speculated;

  // The ROB retires loads in order, so its tag must match the head slot.
  a_retire_tag : assert property (@(posedge clk) disable iff (!n_rst)
    (i_rob_retire_en && !empty && !i_flush) |-> (i_rob_retire_tag == tag_q[head_q]));

endmodule
